// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl
// Bit-serial sequencer around a single 1-bit ALU slice (AND/OR/ADD/SUB/SLT/NOR).
// A start request captures both operands and the control word. The slice then
// processes one bit per cycle, LSB first, and carries between bits. The full
// WIDTH-bit result and its flags are presented together when the operation ends.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous, active-high reset; aborts any operation in flight
//   start    - request; sampled only in IDLE or DONE
//   alu_ctl  - {ainvert, bnegate, op[1:0]}; captured with start
//   a, b     - WIDTH-bit operands; captured with start
//   busy     - high while bits are being processed
//   done     - one-cycle pulse; result and flags are valid from this cycle
//   result   - operation result; held until the next operation completes
//   zero     - result == 0
//   overflow - signed overflow (ADD/SUB/SLT only)
//   cout     - carry out of the MSB (ADD/SUB/SLT only)

module serial_alu_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       ctl;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the low WIDTH-1 result bits. The MSB comes straight from the slice
  // on the final cycle, so it never needs a register of its own.
  logic [WIDTH-2:0] res_sh;
  logic             carry;

  logic             ainvert;
  logic             bnegate;
  logic [1:0]       op;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic             slice_sum;
  logic             slice_cout;
  logic             slice_out;
  logic             legal;
  logic             arith;
  logic             is_slt;
  logic             msb_ovf;
  logic [WIDTH-1:0] full_res;
  logic [WIDTH-1:0] final_res;

  assign ainvert = ctl[3];
  assign bnegate = ctl[2];
  assign op      = ctl[1:0];

  // The shared 1-bit slice. On bit 0, the carry-in is bnegate, which supplies
  // the +1 of the two's-complement subtract.
  always_comb begin
    slice_a    = a_sh[0] ^ ainvert;
    slice_b    = b_sh[0] ^ bnegate;
    slice_cin  = (cnt == '0) ? bnegate : carry;
    slice_sum  = slice_a ^ slice_b ^ slice_cin;
    slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
    case (op)
      2'b00:   slice_out = slice_a & slice_b;
      2'b01:   slice_out = slice_a | slice_b;
      default: slice_out = slice_sum;
    endcase
  end

  // The values below are only meaningful on the final (MSB) cycle. At that
  // point the slice carry-in and carry-out give the signed overflow.
  // SLT replaces the assembled difference with the overflow-corrected sign bit.
  always_comb begin
    case (ctl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    arith    = legal & op[1];
    is_slt   = (ctl == 4'b0111);
    msb_ovf  = slice_cin ^ slice_cout;
    full_res = {slice_out, res_sh};
    if (!legal)
      final_res = '0;
    else if (is_slt)
      final_res = {{(WIDTH-1){1'b0}}, slice_sum ^ msb_ovf};
    else
      final_res = full_res;
  end

  // Sequencer. The visible result and flags change only when the operation
  // completes, so they keep the previous operation's values throughout RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      cout     <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      ctl      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            carry <= 1'b0;
            ctl   <= alu_ctl;
            a_sh  <= a;
            b_sh  <= b;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= full_res[WIDTH-1:1];
          carry  <= slice_cout;
          if (cnt == LAST) begin
            cnt      <= '0;
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= final_res;
            zero     <= (final_res == '0);
            overflow <= arith & msb_ovf;
            cout     <= arith & slice_cout;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl
// Self-checking bench for serial_alu_ctrl (WIDTH=8). Runs the directed vector
// table, then hand-written timing sequences, then randomized operations that
// are compared against a plain-arithmetic reference model.

module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   alu_ctl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         cout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         c;
  } vec_t;

  vec_t vecs[$];

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_ctl  (alu_ctl),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .cout     (cout)
  );

  // The free-running clock has a 10-unit period. Outputs are sampled on the
  // falling edge.
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and keeps the counts.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model that computes results with whole-word arithmetic and
  // signed compares.
  task automatic model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic z, output logic o, output logic co);
    logic [W:0] s;
    r  = '0;
    o  = 1'b0;
    co = 1'b0;
    case (c)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b1100: r = ~(x | y);
      4'b0010: begin
        s  = {1'b0, x} + {1'b0, y};
        r  = s[W-1:0];
        co = s[W];
        o  = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'b0110, 4'b0111: begin
        s  = {1'b0, x} + {1'b0, ~y} + 1;
        r  = s[W-1:0];
        co = s[W];
        o  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        if (c == 4'b0111) r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      end
      default: r = '0;
    endcase
    z = (r == '0);
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] r, input logic z, input logic o, input logic co);
    vec_t v;
    v.ctl = c; v.a = x; v.b = y; v.res = r; v.z = z; v.o = o; v.c = co;
    return v;
  endfunction

  // Issues one operation and returns the number of falling edges from the
  // capturing edge to the done pulse. The operand inputs are scrambled after
  // capture so that the bench shows they are latched.
  task automatic applyStimulus(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                               output int lat);
    @(negedge clk);
    alu_ctl = c; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); alu_ctl = 4'($urandom);
    lat = 1;
    while (!done && lat < W + 6) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runAndCheck(input string name, input logic [3:0] c, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] er, input logic ez,
                             input logic eo, input logic ec);
    int lat;
    applyStimulus(c, x, y, lat);
    checkOutput({name, " latency"}, 64'(lat), 64'(W + 1));
    checkOutput({name, " result"}, 64'(result), 64'(er));
    checkOutput({name, " zero"}, 64'(zero), 64'(ez));
    checkOutput({name, " overflow"}, 64'(overflow), 64'(eo));
    checkOutput({name, " cout"}, 64'(cout), 64'(ec));
  endtask

  // Counts done pulses over a window of idle cycles. Any done here is spurious.
  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  // Main test sequence.
  initial begin
    int lat;
    int n;
    int m;
    logic [3:0]   rc;
    logic [W-1:0] ra, rb, er;
    logic         ez, eo, ec;
    logic [3:0]   legal_codes [6];

    legal_codes[0] = 4'b0000; legal_codes[1] = 4'b0001; legal_codes[2] = 4'b0010;
    legal_codes[3] = 4'b0110; legal_codes[4] = 4'b0111; legal_codes[5] = 4'b1100;

    vecs.push_back(mk(4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(4'b0111, 8'h01, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(4'b1100, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0001, 8'h12, 8'h40, 8'h52, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0110, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0101, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0111, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, 1'b0));

    // Reset state
    rst = 1'b1; start = 1'b0; alu_ctl = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset result", 64'(result), 64'(0));
    checkOutput("reset zero", 64'(zero), 64'(0));
    checkOutput("reset overflow", 64'(overflow), 64'(0));
    checkOutput("reset cout", 64'(cout), 64'(0));
    rst = 1'b0;

    // Directed vector table
    foreach (vecs[i])
      runAndCheck($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].z, vecs[i].o, vecs[i].c);

    // A start pulse during RUN is ignored and produces no extra done
    @(negedge clk);
    alu_ctl = 4'b0010; a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < W + 6) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        start = 1'b1; alu_ctl = 4'b0110; a = 8'hFF; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
    end
    checkOutput("ignored-start latency", 64'(n), 64'(W + 1));
    checkOutput("ignored-start result", 64'(result), 64'(8'h30));
    start = 1'b0;
    countDones(12, m);
    checkOutput("ignored-start extra done", 64'(m), 64'(0));
    checkOutput("ignored-start idle busy", 64'(busy), 64'(0));

    // start held through DONE gives back-to-back operations
    @(negedge clk);
    alu_ctl = 4'b0010; a = 8'h7F; b = 8'h01; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alu_ctl = 4'b0110; a = 8'h05; b = 8'h05;
    n = 1;
    while (!done && n < W + 6) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b2b first latency", 64'(n), 64'(W + 1));
    checkOutput("b2b first result", 64'(result), 64'(8'h80));
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b no gap busy", 64'(busy), 64'(1));
    m = 1;
    while (!done && m < W + 6) begin
      @(negedge clk);
      m++;
    end
    checkOutput("b2b second spacing", 64'(m), 64'(W + 1));
    checkOutput("b2b second result", 64'(result), 64'(8'h00));
    checkOutput("b2b second zero", 64'(zero), 64'(1));
    checkOutput("b2b second cout", 64'(cout), 64'(1));
    @(negedge clk);
    checkOutput("done one-cycle pulse", 64'(done), 64'(0));

    // A reset at RUN bit 3 aborts the operation
    runAndCheck("pre-abort", 4'b0010, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    alu_ctl = 4'b0010; a = 8'h01; b = 8'h02; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort busy before rst", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", 64'(busy), 64'(0));
    checkOutput("abort done", 64'(done), 64'(0));
    checkOutput("abort result", 64'(result), 64'(0));
    countDones(12, m);
    checkOutput("abort no done", 64'(m), 64'(0));

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) rc = 4'($urandom);
      else rc = legal_codes[$urandom_range(0, 5)];
      ra = W'($urandom);
      rb = W'($urandom);
      model(rc, ra, rb, er, ez, eo, ec);
      runAndCheck($sformatf("rand%0d ctl=%b a=%h b=%h", i, rc, ra, rb), rc, ra, rb, er, ez, eo, ec);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
